regfile_init_writer: RTL and testbench
======================================

Name: regfile_init_writer

Overview:
Write-side sequencer for the simple dual-port register-file RAM; it drives write port A (ena/wea/addra/dia).
After reset or on request, it sweeps every RAM word and loads defined initial values: zero, plus sp and tp presets.
Once the sweep completes, it passes core write-back traffic through to port A.
It sits between the core write-back stage and the register-file RAM; the RAM's read port B is untouched.

Parameters:
DATA_WIDTH, 32, RAM word width
ADDR_WIDTH, 5, RAM address width
DATA_DEPTH, 32, number of words swept (must be ≤ 2**ADDR_WIDTH)
SP_INDEX, 2, address receiving SP_INIT
SP_INIT, 32'h40000000, initial stack pointer value
TP_INDEX, 4, address receiving TP_INIT
TP_INIT, 32'h10000000, initial thread/heap pointer value

Ports:
clk  in  1  clock
hwrst  in  1  asynchronous, active-high reset
init_req  in  1  single-cycle request to re-run the initialisation sweep
core_we  in  1  core write-back enable
core_waddr  in  ADDR_WIDTH  core write address
core_wdata  in  DATA_WIDTH  core write data
ena  out  1  RAM port A enable
wea  out  1  RAM port A write enable
addra  out  ADDR_WIDTH  RAM port A address
dia  out  DATA_WIDTH  RAM port A write data
busy  out  1  high while not READY; the core must stall
wr_dropped  out  1  one-cycle pulse: a core write was discarded

Behaviour:
- Interface: one clock, clk; hwrst is asynchronous, active-high. All state and outputs are registered.
- Reset values (while hwrst is high):
  - state = START, cnt = 0
  - ena = wea = 0, addra = 0, dia = 0
  - busy = 1, wr_dropped = 0
- FSM states: START, CLEAR, READY.
- START: on the first clk edge after hwrst deasserts, go to CLEAR with cnt = 0. Port A stays idle on this edge.
- CLEAR: on each edge, register the following, then increment cnt:
  - ena = 1, wea = 1, addra = cnt
  - dia = SP_INIT if cnt == SP_INDEX; TP_INIT if cnt == TP_INDEX; else 0
- Leaving CLEAR: on the edge where cnt == DATA_DEPTH-1, present the last write, clear cnt to 0, go to READY, and register busy = 0.
- Sweep timing: exactly DATA_DEPTH consecutive write cycles; no gaps; addresses strictly ascending from 0.
- READY pass-through: on each edge, register ena = wea = core_we, addra = core_waddr, dia = core_wdata. Latency from core inputs to port A is 1 cycle.
- READY idle: when core_we = 0, ena = wea = 0; addra and dia hold their previous values.
- init_req in READY: go to CLEAR with cnt = 0 and busy = 1 at that edge. Port A is idle on that edge.
  - If core_we is also high on the same edge: init_req wins, the core write is discarded, and wr_dropped pulses.
- init_req in START or CLEAR: ignored; the sweep does not restart.
- core_we while state != READY: the write is discarded and wr_dropped = 1 for the following cycle. Otherwise wr_dropped = 0.
- No overlap: the last sweep write and the first core write can never share a cycle. A core write accepted on the first READY edge appears one cycle after the last sweep write.
- hwrst mid-sweep: asynchronously abort to START; the sweep then restarts from address 0 after deassertion.
- Addresses ≥ DATA_DEPTH are never written by the sweep. Core writes to any address are passed through unchanged, including address 0; the zero-register policy belongs to the core.
- SP_INDEX == TP_INDEX is illegal. If it occurs, SP_INIT takes priority.

Test Plan:
- Reset release, DATA_DEPTH=32 → port A idle for 1 cycle, then 32 consecutive writes to addr 0..31. dia is 0 except 0x40000000 at addr 2 and 0x10000000 at addr 4. busy falls on the edge presenting addr 31.
- READY, core_we=1, waddr=5, wdata=0xDEADBEEF → next cycle ena=wea=1, addra=5, dia=0xDEADBEEF; wr_dropped=0.
- core_we=1 during CLEAR (addr 7, data 0x1) → no port A write of 0x1; wr_dropped pulses for exactly 1 cycle; the sweep sequence is unchanged.
- READY, init_req=1 together with core_we=1 (addr 3) → wr_dropped pulses, busy=1, and a full 32-write sweep follows. Addr 3 is written 0, never the core data.
- hwrst asserted when the sweep reaches addr 10 → outputs return to reset values immediately (asynchronously). After release, the sweep restarts at addr 0 and completes all 32 writes.
- init_req pulsed during CLEAR at addr 20 → ignored; the sweep ends at addr 31 with no restart; busy falls once.

Source files
------------

// File: rtl/regfile_init_writer_if.sv
// Bundle between core write-back, the init writer and RAM write port A.
// Latency: none, signal bundle only.
// Backpressure: busy tells the core to stall; there is no ready handshake.
interface regfile_init_writer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   // core write-back side
   logic                  init_req;
   logic                  core_we;
   logic [ADDR_WIDTH-1:0] core_waddr;
   logic [DATA_WIDTH-1:0] core_wdata;
   // RAM port A side
   logic                  ena;
   logic                  wea;
   logic [ADDR_WIDTH-1:0] addra;
   logic [DATA_WIDTH-1:0] dia;
   // status back to the core
   logic                  busy;
   logic                  wr_dropped;

   // the writer: consumes core traffic, drives port A and status
   modport master (
      input  init_req, core_we, core_waddr, core_wdata,
      output ena, wea, addra, dia, busy, wr_dropped
   );

   // the surroundings: core drives requests, RAM and core observe port A/status
   modport slave (
      output init_req, core_we, core_waddr, core_wdata,
      input  ena, wea, addra, dia, busy, wr_dropped
   );
endinterface

// File: rtl/regfile_init_writer.sv
// Sweeps the register-file RAM with initial values, then forwards core writes to port A.
// Latency: 1 cycle core inputs to port A; sweep takes DATA_DEPTH cycles after one idle cycle.
// Backpressure: busy high while not READY; core writes offered then are dropped and flagged.
module regfile_init_writer #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 5,
   parameter int                    DATA_DEPTH = 32,
   parameter int                    SP_INDEX   = 2,
   parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h40000000,
   parameter int                    TP_INDEX   = 4,
   parameter logic [DATA_WIDTH-1:0] TP_INIT    = 32'h10000000
) (
   input  logic                  clk,
   input  logic                  hwrst,
   regfile_init_writer_if.master bus
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DATA_DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] SP_IDX   = ADDR_WIDTH'(SP_INDEX);
   localparam logic [ADDR_WIDTH-1:0] TP_IDX   = ADDR_WIDTH'(TP_INDEX);

   typedef enum logic [1:0] {
      START,
      CLEAR,
      READY
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] cnt;

   // Sweep word for the current address; SP wins should the two presets collide.
   function automatic logic [DATA_WIDTH-1:0] init_word(input logic [ADDR_WIDTH-1:0] a);
      if (a == SP_IDX)      return SP_INIT;
      else if (a == TP_IDX) return TP_INIT;
      else                  return '0;
   endfunction

   // Sequencer: reset idle cycle, init sweep, then registered pass-through of core writes.
   always_ff @(posedge clk or posedge hwrst) begin
      if (hwrst) begin
         state          <= START;
         cnt            <= '0;
         bus.ena        <= 1'b0;
         bus.wea        <= 1'b0;
         bus.addra      <= '0;
         bus.dia        <= '0;
         bus.busy       <= 1'b1;
         bus.wr_dropped <= 1'b0;
      end else begin
         bus.wr_dropped <= 1'b0;
         case (state)
            START: begin
               state          <= CLEAR;
               cnt            <= '0;
               bus.ena        <= 1'b0;
               bus.wea        <= 1'b0;
               bus.wr_dropped <= bus.core_we;
            end
            CLEAR: begin
               // init_req is deliberately ignored here: a sweep never restarts itself
               bus.ena        <= 1'b1;
               bus.wea        <= 1'b1;
               bus.addra      <= cnt;
               bus.dia        <= init_word(cnt);
               bus.wr_dropped <= bus.core_we;
               if (cnt == LAST_IDX) begin
                  cnt      <= '0;
                  state    <= READY;
                  bus.busy <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            READY: begin
               if (bus.init_req) begin
                  // re-init takes priority; a coincident core write is lost and flagged
                  state          <= CLEAR;
                  cnt            <= '0;
                  bus.busy       <= 1'b1;
                  bus.ena        <= 1'b0;
                  bus.wea        <= 1'b0;
                  bus.wr_dropped <= bus.core_we;
               end else begin
                  bus.ena <= bus.core_we;
                  bus.wea <= bus.core_we;
                  // address/data hold while idle so port A stays quiet
                  if (bus.core_we) begin
                     bus.addra <= bus.core_waddr;
                     bus.dia   <= bus.core_wdata;
                  end
               end
            end
            default: begin
               state    <= START;
               cnt      <= '0;
               bus.ena  <= 1'b0;
               bus.wea  <= 1'b0;
               bus.busy <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_init_writer.sv
// Directed bench for regfile_init_writer: sweeps, pass-through, drops, re-init and async reset.
// Latency: inputs change 1 time unit after a rising edge; outputs are checked at that point.
// Backpressure: core writes are offered while busy to exercise the drop path.
module tb_regfile_init_writer;

   localparam logic [31:0] SP_VAL = 32'h40000000;
   localparam logic [31:0] TP_VAL = 32'h10000000;

   logic clk;
   logic hwrst;
   int   n_checks;
   int   n_fail;

   regfile_init_writer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

   regfile_init_writer dut (
      .clk   (clk),
      .hwrst (hwrst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_dia(input int a);
      if (a == 2)      return SP_VAL;
      else if (a == 4) return TP_VAL;
      else             return 32'h0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ena"},  32'(bus.ena),        32'd0);
      chk({tag, "_wea"},  32'(bus.wea),        32'd0);
      chk({tag, "_addr"}, 32'(bus.addra),      32'd0);
      chk({tag, "_dia"},  32'(bus.dia),        32'd0);
      chk({tag, "_busy"}, 32'(bus.busy),       32'd1);
      chk({tag, "_drop"}, 32'(bus.wr_dropped), 32'd0);
   endtask

   // n sweep cycles; optionally offer a core write (addr 7, data 1) or an init_req at one index
   task automatic run_sweep(input string tag, input int n, input int drop_at, input int init_at);
      for (int i = 0; i < n; i++) begin
         bus.core_we    = (i == drop_at);
         bus.core_waddr = 5'd7;
         bus.core_wdata = 32'h1;
         bus.init_req   = (i == init_at);
         step();
         chk($sformatf("%s_en%0d", tag, i),   32'({bus.ena, bus.wea}), 32'd3);
         chk($sformatf("%s_addr%0d", tag, i), 32'(bus.addra),          32'(i));
         chk($sformatf("%s_dia%0d", tag, i),  bus.dia,                 exp_dia(i));
         chk($sformatf("%s_busy%0d", tag, i), 32'(bus.busy),           (i == 31) ? 32'd0 : 32'd1);
         chk($sformatf("%s_drop%0d", tag, i), 32'(bus.wr_dropped),     (i == drop_at) ? 32'd1 : 32'd0);
      end
      bus.core_we  = 1'b0;
      bus.init_req = 1'b0;
   endtask

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      hwrst          = 1'b1;
      bus.init_req   = 1'b0;
      bus.core_we    = 1'b0;
      bus.core_waddr = '0;
      bus.core_wdata = '0;

      #12;
      chk_reset_vals("rst");
      hwrst = 1'b0;

      // START edge: port idle, still busy
      step();
      chk("start_ena",  32'(bus.ena),  32'd0);
      chk("start_busy", 32'(bus.busy), 32'd1);
      run_sweep("sw1", 32, -1, -1);

      // pass-through with 1-cycle latency
      bus.core_we = 1'b1; bus.core_waddr = 5'd5; bus.core_wdata = 32'hDEADBEEF;
      step();
      chk("pt_en",   32'({bus.ena, bus.wea}), 32'd3);
      chk("pt_addr", 32'(bus.addra),          32'd5);
      chk("pt_dia",  bus.dia,                 32'hDEADBEEF);
      chk("pt_drop", 32'(bus.wr_dropped),     32'd0);
      chk("pt_busy", 32'(bus.busy),           32'd0);

      // core write to address 0 passes through unchanged
      bus.core_waddr = 5'd0; bus.core_wdata = 32'hCAFEF00D;
      step();
      chk("pt0_addr", 32'(bus.addra), 32'd0);
      chk("pt0_dia",  bus.dia,        32'hCAFEF00D);

      // idle in READY: enables drop, addr/data hold
      bus.core_we = 1'b0; bus.core_waddr = 5'd9; bus.core_wdata = 32'h55555555;
      step();
      chk("idle_en",   32'({bus.ena, bus.wea}), 32'd0);
      chk("idle_addr", 32'(bus.addra),          32'd0);
      chk("idle_dia",  bus.dia,                 32'hCAFEF00D);

      // init_req collides with a core write: request wins, write dropped
      bus.init_req = 1'b1; bus.core_we = 1'b1; bus.core_waddr = 5'd3; bus.core_wdata = 32'h12345678;
      step();
      bus.init_req = 1'b0; bus.core_we = 1'b0;
      chk("ri_ena",  32'(bus.ena),        32'd0);
      chk("ri_drop", 32'(bus.wr_dropped), 32'd1);
      chk("ri_busy", 32'(bus.busy),       32'd1);
      // this sweep also takes a core write while clearing, at addr 7
      run_sweep("sw2", 32, 7, -1);

      // re-init, then assert reset asynchronously once addr 10 is presented
      bus.init_req = 1'b1;
      step();
      bus.init_req = 1'b0;
      chk("ri2_busy", 32'(bus.busy), 32'd1);
      run_sweep("sw3", 11, -1, -1);
      hwrst = 1'b1;
      #1;
      chk_reset_vals("arst");
      step();
      chk_reset_vals("arst_hold");
      @(negedge clk);
      hwrst = 1'b0;
      step();
      chk("start2_ena",  32'(bus.ena),  32'd0);
      chk("start2_busy", 32'(bus.busy), 32'd1);

      // init_req during CLEAR at addr 20 is ignored
      run_sweep("sw4", 32, -1, 20);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("post_en%0d", k),   32'(bus.ena),  32'd0);
         chk($sformatf("post_busy%0d", k), 32'(bus.busy), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
